// File: rtl/a2d_seq_pkg.sv
// Shared types, widths and the A2D command encoding for the multi-channel sequencer.
package a2d_seq_pkg;

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} frame_state_t;

  localparam int DATA_W     = 12;
  localparam int FRAME_BITS = 16;

  // The A2D takes its channel address in bits [13:11]; all other bits are don't-care zeros.
  function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'b0};
  endfunction

endpackage

// File: rtl/a2d_seq_spi_frame.sv
// One 16-bit SPI transaction: SS_n low, a half-period front porch, 16 SCLK periods, a half-period back porch.
module spi_frame
  import a2d_seq_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] cmd,
  input  logic                  miso,
  output logic                  ss_n,
  output logic                  sclk,
  output logic                  mosi,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_done,
  output logic                  done
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int CW   = $clog2(SCLK_DIV) + 1;

  frame_state_t          state;
  logic [CW-1:0]         cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] tx;

  // The receive register is only DATA_W wide, so the four leading status bits fall off the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ss_n    <= 1'b1;
      sclk    <= 1'b1;
      mosi    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
      done    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FRONT;
            ss_n  <= 1'b0;
            tx    <= cmd;
            cnt   <= '0;
          end
        end
        FRONT: begin
          if (cnt == CW'(HALF - 1)) begin
            state   <= SHIFT;
            sclk    <= 1'b0;
            mosi    <= tx[FRAME_BITS-1];
            tx      <= {tx[FRAME_BITS-2:0], 1'b0};
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CW'(HALF - 1)) begin
            sclk    <= 1'b1;
            rx_data <= {rx_data[DATA_W-2:0], miso};
            rx_done <= (bit_cnt == 4'd15);
            cnt     <= cnt + 1'b1;
          end else if (cnt == CW'(SCLK_DIV - 1)) begin
            cnt <= '0;
            if (bit_cnt == 4'd15) begin
              state <= BACK;
            end else begin
              sclk    <= 1'b0;
              mosi    <= tx[FRAME_BITS-1];
              tx      <= {tx[FRAME_BITS-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BACK: begin
          if (cnt == CW'(HALF - 1)) begin
            state <= IDLE;
            ss_n  <= 1'b1;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/a2d_seq.sv
// Round-robin A2D sequencer: pipelined channel addressing, per-channel averaging and offset removal with clamp at zero.
module a2d_seq
  import a2d_seq_pkg::*;
#(
  parameter int          NUM_CH   = 3,
  parameter int          SCLK_DIV = 32,
  parameter int          AVG_LOG2 = 2,
  parameter logic [11:0] OFFSET   = 12'h260
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic                     SS_n,
  output logic                     SCLK,
  output logic                     MOSI,
  input  logic                     MISO,
  output logic [NUM_CH*DATA_W-1:0] rdata,
  output logic [NUM_CH-1:0]        vld,
  output logic                     sweep_done
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int GAP_W = $clog2(SCLK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  frame_state_t      state;
  logic              start, rx_done, frame_done, primed;
  logic [DATA_W-1:0] rx_data;
  logic [2:0]        ptr, cur_ch, prev_ch, ptr_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];

  logic [ACC_W-1:0]  sel_acc, sum;
  logic [CNT_W-1:0]  sel_cnt;
  logic [DATA_W-1:0] avg, result;
  logic              last;

  spi_frame #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cmd     (cmd_word(cur_ch)),
    .miso    (MISO),
    .ss_n    (SS_n),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .done    (frame_done)
  );

  assign ptr_next = (ptr == 3'(NUM_CH - 1)) ? 3'd0 : ptr + 3'd1;

  // The incoming sample belongs to the channel addressed one frame earlier.
  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (prev_ch == 3'(i)) begin
        sel_acc = acc[i];
        sel_cnt = cnt[i];
      end
    end
    sum    = sel_acc + ACC_W'(rx_data);
    avg    = sum[ACC_W-1:AVG_LOG2];
    result = (avg >= OFFSET) ? avg - OFFSET : '0;
    last   = (sel_cnt == LAST);
  end

  // Here FRONT stands for "a frame is in flight"; the SPI engine tracks the finer phases itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start      <= 1'b0;
      primed     <= 1'b0;
      ptr        <= '0;
      cur_ch     <= '0;
      prev_ch    <= '0;
      gap_cnt    <= '0;
      rdata      <= '0;
      vld        <= '0;
      sweep_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      start      <= 1'b0;
      vld        <= '0;
      sweep_done <= 1'b0;
      if (rx_done) begin
        primed  <= 1'b1;
        prev_ch <= cur_ch;
        if (primed) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (prev_ch == 3'(i)) begin
              if (last) begin
                acc[i]                  <= '0;
                cnt[i]                  <= '0;
                rdata[i*DATA_W +: DATA_W] <= result;
                vld[i]                  <= 1'b1;
                sweep_done              <= (i == NUM_CH - 1);
              end else begin
                acc[i] <= sum;
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
          end
        end
      end
      case (state)
        IDLE: begin
          if (en) begin
            start  <= 1'b1;
            cur_ch <= ptr;
            ptr    <= ptr_next;
            state  <= FRONT;
          end
        end
        FRONT: begin
          if (frame_done) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          // Launching three clocks early lets SS_n rise-to-fall span exactly SCLK_DIV clocks.
          if (gap_cnt == GAP_W'(SCLK_DIV - 3)) begin
            if (en) begin
              start  <= 1'b1;
              cur_ch <= ptr;
              ptr    <= ptr_next;
              state  <= FRONT;
            end else begin
              state  <= IDLE;
              primed <= 1'b0;
              ptr    <= '0;
              for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
              end
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_seq.sv
// Directed bench: a 3-channel unaveraged sequencer and a 1-channel 4x-averaging one, each against a pipelined A2D model.
module tb_a2d_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic        ss_n_a, sclk_a, mosi_a, miso_a;
  logic        ss_n_b, sclk_b, mosi_b, miso_b;
  logic [35:0] rdata_a;
  logic [11:0] rdata_b;
  logic [2:0]  vld_a;
  logic [0:0]  vld_b;
  logic        sweep_a, sweep_b;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  a2d_seq #(.NUM_CH(3), .SCLK_DIV(32), .AVG_LOG2(0), .OFFSET(12'h260)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .SS_n(ss_n_a), .SCLK(sclk_a), .MOSI(mosi_a),
    .MISO(miso_a), .rdata(rdata_a), .vld(vld_a), .sweep_done(sweep_a)
  );

  a2d_seq #(.NUM_CH(1), .SCLK_DIV(32), .AVG_LOG2(2), .OFFSET(12'h260)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .SS_n(ss_n_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .MISO(miso_b), .rdata(rdata_b), .vld(vld_b), .sweep_done(sweep_b)
  );

  // A2D model A: answers each frame with the channel addressed by the previous frame.
  logic [11:0] val_a [0:7];
  logic [15:0] tx_a, cmd_a = '0;
  logic [2:0]  prev_a = '0;
  logic [2:0]  ch_q [$];

  always @(negedge ss_n_a) begin tx_a = {4'h0, val_a[prev_a]}; cmd_a = '0; end
  always @(negedge sclk_a) if (!ss_n_a) begin miso_a = tx_a[15]; tx_a = {tx_a[14:0], 1'b0}; end
  always @(posedge sclk_a) if (!ss_n_a) cmd_a = {cmd_a[14:0], mosi_a};
  always @(posedge ss_n_a) if (rst_n) begin prev_a = cmd_a[13:11]; ch_q.push_back(cmd_a[13:11]); end

  // A2D model B: a ramp of 4 per frame so that frames 2..5 return 300,304,308,30C.
  logic [15:0] tx_b, cmd_b = '0;
  int          frames_b = 0;

  always @(negedge ss_n_b) begin frames_b++; tx_b = {4'h0, 12'h2F8 + 12'(4 * frames_b)}; cmd_b = '0; end
  always @(negedge sclk_b) if (!ss_n_b) begin miso_b = tx_b[15]; tx_b = {tx_b[14:0], 1'b0}; end
  always @(posedge sclk_b) if (!ss_n_b) cmd_b = {cmd_b[14:0], mosi_b};

  // Event monitor, sampled 1 time unit after each rising edge.
  int          fall_cnt = 0, vld_cnt = 0, sweep_cnt = 0, sweep_err = 0;
  logic        ss_prev = 1'b1;
  logic [2:0]  vld_q [$];
  int          vfall_q [$];
  logic [11:0] b_q [$];
  int          bf_q [$];

  always @(posedge clk) begin
    #1;
    if (!ss_n_a && ss_prev) fall_cnt++;
    ss_prev = ss_n_a;
    if (vld_a != 3'b000) begin vld_cnt++; vld_q.push_back(vld_a); vfall_q.push_back(fall_cnt); end
    if (sweep_a) sweep_cnt++;
    if (sweep_a !== vld_a[2]) sweep_err++;
    if (sweep_b !== vld_b[0]) sweep_err++;
    if (vld_b[0]) begin b_q.push_back(rdata_b); bf_q.push_back(frames_b); end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input int cycles);
    en_a = en_v;
    repeat (cycles) @(negedge clk);
  endtask

  logic sc [0:599];
  logic ss [0:599];
  int   lo_start, lo_len, hi_len, ss_low, gap, rises, v0, f0, s0, j;

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b1; miso_a = 1'b0; miso_b = 1'b0;
    val_a[0] = 12'h800; val_a[1] = 12'h801; val_a[2] = 12'h802;
    for (int i = 3; i < 8; i++) val_a[i] = 12'h000;
    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_ss_n", ss_n_a, 1'b1);
    checkOutput("rst_sclk", sclk_a, 1'b1);
    checkOutput("rst_mosi", mosi_a, 1'b0);
    checkOutput("rst_rdata", rdata_a, 36'h0);
    checkOutput("rst_vld", vld_a, 3'b000);
    checkOutput("rst_sweep", sweep_a, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    en_a = 1'b1;
    @(posedge clk); #1;
    checkOutput("ss_n_before_launch", ss_n_a, 1'b1);
    @(posedge clk); #1;
    checkOutput("ss_n_falls", ss_n_a, 1'b0);

    $display("[TB] frame timing");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      sc[i] = sclk_a;
      ss[i] = ss_n_a;
    end
    lo_start = 0;
    for (int i = 0; i < 600; i++) if (!sc[i]) begin lo_start = i; break; end
    j = lo_start;
    while (j < 600 && !sc[j]) j++;
    lo_len = j - lo_start;
    hi_len = 0;
    while (j < 600 && sc[j]) begin j++; hi_len++; end
    ss_low = 0;
    while (ss_low < 600 && !ss[ss_low]) ss_low++;
    gap = 0;
    while (ss_low + gap < 600 && ss[ss_low + gap]) gap++;
    rises = 0;
    for (int i = 1; i < 600; i++) if (sc[i] && !sc[i-1] && !ss[i]) rises++;
    checkOutput("front_porch", lo_start, 16);
    checkOutput("sclk_low", lo_len, 16);
    checkOutput("sclk_high", hi_len, 16);
    checkOutput("ss_n_low", ss_low, 544);
    checkOutput("ss_n_gap", gap, 32);
    checkOutput("frame_period", ss_low + gap, 576);
    checkOutput("sclk_rises", rises, 16);

    $display("[TB] first sweep");
    for (int i = 0; i < 4000 && sweep_cnt < 1; i++) @(negedge clk);
    checkOutput("vld_0", vld_q[0], 3'b001);
    checkOutput("vld_1", vld_q[1], 3'b010);
    checkOutput("vld_2", vld_q[2], 3'b100);
    checkOutput("first_vld_frame", vfall_q[0], 2);
    checkOutput("rdata_sweep1", rdata_a, {12'h5A2, 12'h5A1, 12'h5A0});
    for (int i = 0; i < 1000 && ch_q.size() < 4; i++) @(negedge clk);
    checkOutput("mosi_ch0", ch_q[0], 3'd0);
    checkOutput("mosi_ch1", ch_q[1], 3'd1);
    checkOutput("mosi_ch2", ch_q[2], 3'd2);
    checkOutput("mosi_ch3", ch_q[3], 3'd0);

    $display("[TB] clamp at zero");
    val_a[1] = 12'h100;
    s0 = sweep_cnt;
    for (int i = 0; i < 5000 && sweep_cnt < s0 + 2; i++) @(negedge clk);
    checkOutput("rdata_clamp", rdata_a, {12'h5A2, 12'h000, 12'h5A0});

    $display("[TB] averaging channel");
    for (int i = 0; i < 6000 && b_q.size() < 2; i++) @(negedge clk);
    checkOutput("avg1_value", b_q[0], 12'h0A6);
    checkOutput("avg1_frame", bf_q[0], 5);
    checkOutput("avg2_value", b_q[1], 12'h0B6);
    checkOutput("avg2_frame", bf_q[1], 9);
    checkOutput("b_cmd_ch0", cmd_b, 16'h0000);

    $display("[TB] en dropped mid-frame");
    for (int i = 0; i < 1000 && ss_n_a !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 1000 && ss_n_a !== 1'b0; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    v0 = vld_cnt; f0 = fall_cnt;
    applyStimulus(1'b0, 1500);
    checkOutput("drop_vld_count", vld_cnt - v0, 1);
    checkOutput("drop_no_new_frame", fall_cnt - f0, 0);
    checkOutput("drop_ss_n_idle", ss_n_a, 1'b1);
    checkOutput("drop_sclk_idle", sclk_a, 1'b1);
    checkOutput("drop_rdata_hold", rdata_a, {12'h5A2, 12'h000, 12'h5A0});

    v0 = vld_cnt; f0 = fall_cnt;
    en_a = 1'b1;
    for (int i = 0; i < 2000 && fall_cnt < f0 + 2; i++) @(negedge clk);
    checkOutput("reprime_frames", fall_cnt - f0, 2);
    checkOutput("reprime_no_vld", vld_cnt - v0, 0);

    $display("[TB] reset mid-frame");
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ss_n", ss_n_a, 1'b1);
    checkOutput("mid_rst_sclk", sclk_a, 1'b1);
    checkOutput("mid_rst_mosi", mosi_a, 1'b0);
    checkOutput("mid_rst_rdata", rdata_a, 36'h0);
    checkOutput("mid_rst_vld", vld_a, 3'b000);
    checkOutput("mid_rst_sweep", sweep_a, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = vld_cnt; f0 = fall_cnt;
    for (int i = 0; i < 2000 && fall_cnt < f0 + 2; i++) @(negedge clk);
    checkOutput("restart_no_vld", vld_cnt - v0, 0);
    for (int i = 0; i < 1000 && vld_a == 3'b000; i++) @(negedge clk);
    checkOutput("restart_vld", vld_a, 3'b001);
    checkOutput("restart_rdata", rdata_a, {12'h000, 12'h000, 12'h5A0});

    checkOutput("sweep_with_last_vld", sweep_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/a2d_seq.md
# a2d_seq

Parametrised multi-channel A2D sequencer for the DE0 on-board 12-bit SPI A2D; successor to the single-channel throttle reader. It continuously round-robins NUM_CH channels and pipelines the channel address of frame k with the result of frame k-1. It averages 2^AVG_LOG2 samples per channel and subtracts a fixed offset with clamp-at-zero, replacing wrap-around subtraction. Results feed the brushless controller, which uses drv_mag from ch0, and debug LEDs.

## Interface
- NUM_CH, 3: channels sequenced, 1..8; A2D channel numbers 0..NUM_CH-1.
- SCLK_DIV, 32: clk cycles per SCLK period; even, ≥4.
- AVG_LOG2, 2: log2 of samples averaged per channel, 0..4.
- OFFSET, 12'h260: subtracted from every averaged result.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock, 50 MHz.
  - rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; level-sensitive.
- SS_n  out  1  A2D slave select, active low.
- SCLK  out  1  SPI clock; idles high.
- MOSI  out  1  serial command to the A2D.
- MISO  in  1  serial data from the A2D.
- rdata  out  NUM_CH*12  packed results; ch i occupies bits [12i+11:12i].
- vld  out  NUM_CH  one-clk pulse on bit i when rdata ch i updates.
- sweep_done  out  1  one-clk pulse coincident with vld[NUM_CH-1].

## Operation
- Frame FSM states:
  - IDLE: SS_n=1, SCLK=1.
  - FRONT: SS_n=0, SCLK high for SCLK_DIV/2 clks.
  - SHIFT: 16 SCLK periods, each low then high for SCLK_DIV/2 clks.
  - BACK: SCLK high, SS_n=0 for SCLK_DIV/2 clks.
  - GAP: SS_n=1 for SCLK_DIV clks, then go to FRONT if en=1, else IDLE.
- IDLE→FRONT when en=1.
- Command word, MSB first: {2'b00, ch[2:0], 11'b0}. MOSI changes on the clk in which SCLK falls. MISO is sampled on the clk in which SCLK rises.
- Result of a frame = received bits [11:0]; the upper 4 bits are ignored. The result belongs to the channel addressed in the previous frame.
- Channel pointer: 0,1,…,NUM_CH-1, then wraps to 0. NUM_CH=1 addresses ch0 every frame.
- Prime flag: the first frame after reset or after IDLE yields no result, because no channel was previously addressed.
- Averaging: per-channel accumulator, 12+AVG_LOG2 bits, plus a sample counter.
  - On the 2^AVG_LOG2-th sample, avg = acc >> AVG_LOG2.
  - rdata[ch] = (avg ≥ OFFSET) ? avg − OFFSET : 0.
  - Pulse vld[ch]; clear acc and the counter.
- en deasserted mid-frame: the current frame completes, including GAP, and its result is used. The FSM then enters IDLE. Partial accumulators and counters are cleared. rdata is retained.

## Timing
- Reset values:
  - SS_n=1, SCLK=1, MOSI=0.
  - rdata=0, vld=0, sweep_done=0.
  - FSM=IDLE, prime cleared, pointer=0, accumulators=0.
- SS_n falls 1 clk after en is sampled high in IDLE.
- Frame period = 18·SCLK_DIV clks (576 at default), including GAP.
- Result registered, and vld pulsed, 1 clk after the last SCLK rise of the frame carrying it.
- First vld[0] after en occurs in frame 2 when AVG_LOG2=0, and in frame 2^AVG_LOG2·NUM_CH − NUM_CH + 2 in general.
- All outputs are registered; no combinational path from MISO to any output.
- Reset mid-frame: outputs return to reset values immediately (SS_n=1, SCLK=1).

## Structure
- Package a2d_seq_pkg holds:
  - frame state enum;
  - DATA_W=12 and FRAME_BITS=16;
  - function cmd_word(ch) returning the 16-bit command.
- Sub-module spi_frame: one 16-bit SPI transaction engine with start/done handshake, parametrised by SCLK_DIV; owns FRONT/SHIFT/BACK.
- a2d_seq owns the GAP/IDLE control, channel pointer, prime flag, averaging, offset clamp and output registers.

## Test plan
- NUM_CH=3, AVG_LOG2=0, SPI A2D model returning 12'h800+ch; en=1 → MOSI channel order 0,1,2,0; rdata = {12'h5A2, 12'h5A1, 12'h5A0}; vld order 1,2,4; sweep_done with vld[2].
- A2D model returns 12'h100 on ch1 → rdata ch1 = 0 (clamped, no wrap).
- AVG_LOG2=2, ch0 samples 12'h300, 12'h304, 12'h308, 12'h30C → single vld[0]; rdata ch0 = 12'h306 − 12'h260 = 12'h0A6.
- Check timing: frame period 576 clks; SCLK high/low 16 clks each; 16 SCLK rises per frame; SS_n high ≥32 clks between frames.
- Drop en mid-SHIFT → frame completes, SS_n stays 1 afterwards, rdata holds. Re-assert en → first frame produces no vld.
- Assert rst_n=0 mid-frame → SS_n=1, SCLK=1, rdata=0 within the same clk; restart primes again.
